pkt_sche_drain: RTL and testbench
=================================

PKT_SCHE_DRAIN -- requirements
Module: pkt_sche_drain

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, width of scheduler output word (packet address).
REQ-002 SHALL have parameter BUF_DEPTH, default 4, local output buffer entries (power of two, >=2).
REQ-003 SHALL have parameter CRED_WIDTH, default 8, width of credit counter and credit config fields.
REQ-004 SHALL have clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have sch_ready  input  1  scheduler initialised.
REQ-007 SHALL have sch_out_valid  input  1  scheduler head word available.
REQ-008 SHALL have sch_out_data  input  DWIDTH  scheduler head word, valid with sch_out_valid.
REQ-009 SHALL have sch_out_deque_en  output  1  pop request to scheduler.
REQ-010 SHALL have tx_valid / tx_ready / tx_data  output / input / output  1 / 1 / DWIDTH  downstream valid-ready stream.
REQ-011 SHALL have cfg_tick_period  input  16  refill interval in cycles; 0 = unlimited rate.
REQ-012 SHALL have cfg_tokens / cfg_bucket_max  input  CRED_WIDTH each  credits per refill / credit ceiling.
REQ-013 SHALL have flush_req  input  1  stop dequeuing, drain local buffer; flush_done  output  1  one-cycle pulse.

Function
REQ-014 SHALL implement FSM states INIT, RUN, FLUSH.
REQ-015 INIT -> RUN on the first cycle sch_ready=1; no dequeue in INIT.
REQ-016 RUN -> FLUSH when flush_req=1; FLUSH -> RUN when buffer empty and flush_req=0, pulsing flush_done for exactly that transition cycle.
REQ-017 sch_out_deque_en SHALL be combinational: state==RUN & sch_out_valid & fill<BUF_DEPTH & (credit!=0 | cfg_tick_period==0).
REQ-018 Scheduler data is show-ahead: when sch_out_deque_en=1, sch_out_data SHALL be written into the buffer tail at that clock edge.
REQ-019 Full check SHALL use current fill only; a same-cycle tx pop does not permit a push at BUF_DEPTH.
REQ-020 tx_valid SHALL equal fill!=0; tx_data SHALL be the buffer head; pop on tx_valid & tx_ready.
REQ-021 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-022 Simultaneous push and pop SHALL leave fill unchanged; pointers wrap modulo BUF_DEPTH.
REQ-023 Tick counter SHALL count 0..cfg_tick_period-1; on wrap credit <= min(credit + cfg_tokens - consumed, cfg_bucket_max), computed at CRED_WIDTH+1 bits.
REQ-024 Each dequeue SHALL consume one credit; credit never underflows.
REQ-025 With cfg_tick_period==0, credit SHALL be held at cfg_bucket_max and not decremented.
REQ-026 Dequeue-to-tx_valid latency SHALL be 1 cycle when buffer empty.

Reset
REQ-027 On rst: state=INIT, fill=0, pointers=0, tick counter=0, credit=0.
REQ-028 Reset outputs: sch_out_deque_en=0, tx_valid=0, tx_data=0, flush_done=0.
REQ-029 rst mid-transfer SHALL discard buffer contents; no tx beat in the reset cycle or the following cycle.

Configuration
REQ-030 Macro PKT_SCHE_DRAIN_STATS_EN, when defined, SHALL add output drain_cnt (32-bit) counting tx handshakes, reset to 0, wrapping at 2^32.
REQ-031 Without PKT_SCHE_DRAIN_STATS_EN, drain_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-032 Init: sch_ready low 5 cycles, sch_out_valid=1 -> no sch_out_deque_en until cycle after sch_ready=1.
REQ-033 Backpressure: tick_period=0, tx_ready=0, 6 words offered -> exactly 4 dequeues, deque_en low at fill=4, tx_data holds first word.
REQ-034 Rate: tick_period=10, tokens=2, bucket_max=2, scheduler always valid, tx_ready=1 -> 2 dequeues per 10 cycles.
REQ-035 Flush: 3 words buffered, tx_ready=1, flush_req held 8 cycles -> no new dequeues, 3 tx beats, flush_done one pulse after flush_req drops.
REQ-036 Reset mid-stream: rst with fill=3 -> tx_valid=0 next cycle, state INIT, credit=0.
REQ-037 Stats (PKT_SCHE_DRAIN_STATS_EN): 100 tx handshakes -> drain_cnt=100.

Source files
------------

// File: rtl/pkt_sche_drain.sv
// ----------------------------------------------------------------------------
// pkt_sche_drain
//
// Purpose:
//   Drains packet addresses from a show-ahead scheduler into a small local
//   output buffer and presents them on a valid/ready stream. The dequeue rate
//   is limited by a token bucket that is refilled every cfg_tick_period
//   cycles. A flush request stops dequeuing and lets the local buffer empty.
//   flush_done pulses on the cycle the block leaves the flush state.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   sch_ready           - scheduler initialised (leaves INIT)
//   sch_out_valid/data  - scheduler head word (show-ahead)
//   sch_out_deque_en    - pop strobe to the scheduler; the head word is
//                         written into the buffer on the same edge
//   tx_valid/ready/data - downstream valid/ready stream (buffer head)
//   cfg_tick_period     - refill interval in cycles, 0 = unlimited rate
//   cfg_tokens          - credits added per refill
//   cfg_bucket_max      - credit ceiling
//   flush_req           - stop dequeuing and drain the buffer
//   flush_done          - one-cycle pulse when the flush completes
//   drain_cnt           - tx handshake count (only with the option below)
//
// Build option:
//   PKT_SCHE_DRAIN_STATS_EN - adds the 32-bit drain_cnt output counting tx
//                             handshakes (wraps at 2^32).
// ----------------------------------------------------------------------------
module pkt_sche_drain #(
  parameter int DWIDTH     = 32,
  parameter int BUF_DEPTH  = 4,
  parameter int CRED_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sch_ready,
  input  logic                  sch_out_valid,
  input  logic [DWIDTH-1:0]     sch_out_data,
  output logic                  sch_out_deque_en,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DWIDTH-1:0]     tx_data,
  input  logic [15:0]           cfg_tick_period,
  input  logic [CRED_WIDTH-1:0] cfg_tokens,
  input  logic [CRED_WIDTH-1:0] cfg_bucket_max,
  input  logic                  flush_req,
  output logic                  flush_done
`ifdef PKT_SCHE_DRAIN_STATS_EN
  ,
  output logic [31:0]           drain_cnt
`endif
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int FW = AW + 1;

  localparam logic [AW-1:0]         PTR_ONE  = 1;
  localparam logic [FW-1:0]         FILL_ONE = 1;
  localparam logic [FW-1:0]         DEPTH_F  = FW'(BUF_DEPTH);
  localparam logic [CRED_WIDTH-1:0] CRED_ONE = 1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_next;
  logic                  w_done;

  // Buffer is tiny and must be read combinationally at the head so the
  // first word reaches tx_data one cycle after the dequeue; keep it in flops.
  logic [DWIDTH-1:0]     r_buf [BUF_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [FW-1:0]         r_fill;

  logic [15:0]           r_tick;
  logic [CRED_WIDTH-1:0] r_credit;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_not_full;
  logic                  w_not_empty;
  logic                  w_period_zero;
  logic                  w_credit_ok;
  logic [16:0]           w_tick_inc;
  logic                  w_tick_wrap;
  logic [CRED_WIDTH:0]   w_refill;
  logic [CRED_WIDTH-1:0] w_refill_capped;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  // Full test looks at the current fill only: a pop in the same cycle does
  // not open a slot for a push when the buffer is full.
  assign w_not_full    = (r_fill < DEPTH_F);
  assign w_not_empty   = (r_fill != '0);
  assign w_period_zero = (cfg_tick_period == 16'd0);
  assign w_credit_ok   = (r_credit != '0) | w_period_zero;

  // Outputs are forced low while rst is high so nothing is popped or
  // transferred in the reset cycle itself.
  assign w_push = ~rst & (r_state == ST_RUN) & sch_out_valid & w_not_full & w_credit_ok;
  assign w_pop  = ~rst & w_not_empty & tx_ready;

  assign sch_out_deque_en = w_push;
  assign tx_valid         = ~rst & w_not_empty;
  assign tx_data          = tx_valid ? r_buf[r_rd_ptr] : '0;
  assign flush_done       = ~rst & w_done;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (sch_ready) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Leave only once the buffer is empty and the request has dropped;
        // the pulse marks exactly this transition cycle.
        if (!w_not_empty && !flush_req) begin
          w_state_next = ST_RUN;
          w_done       = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf[r_wr_ptr] <= sch_out_data;
    end
  end

  // Pointers are AW bits wide, so the increment wraps modulo BUF_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FILL_ONE;
        2'b01:   r_fill <= r_fill - FILL_ONE;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Token bucket
  // --------------------------------------------------------------------------
  // Wrap when the incremented count reaches the period; using >= also
  // recovers cleanly if the period is shortened below the current count.
  assign w_tick_inc  = {1'b0, r_tick} + 17'd1;
  assign w_tick_wrap = (w_tick_inc >= {1'b0, cfg_tick_period});

  // One extra bit so credit + tokens cannot overflow before the cap.
  // A push always has credit behind it here, so the subtraction never
  // goes negative.
  assign w_refill = {1'b0, r_credit} + {1'b0, cfg_tokens}
                  - {{CRED_WIDTH{1'b0}}, w_push};
  assign w_refill_capped = (w_refill > {1'b0, cfg_bucket_max}) ?
                           cfg_bucket_max : w_refill[CRED_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick   <= 16'd0;
      r_credit <= '0;
    end else if (w_period_zero) begin
      // Unlimited rate: bucket sits at the ceiling and is never consumed.
      r_tick   <= 16'd0;
      r_credit <= cfg_bucket_max;
    end else if (w_tick_wrap) begin
      r_tick   <= 16'd0;
      r_credit <= w_refill_capped;
    end else begin
      r_tick   <= w_tick_inc[15:0];
      if (w_push) begin
        r_credit <= r_credit - CRED_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef PKT_SCHE_DRAIN_STATS_EN
  logic [31:0] r_drain_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_cnt <= 32'd0;
    end else if (w_pop) begin
      r_drain_cnt <= r_drain_cnt + 32'd1;
    end
  end

  assign drain_cnt = r_drain_cnt;
`endif

endmodule

// File: tb/tb_pkt_sche_drain.sv
// ----------------------------------------------------------------------------
// tb_pkt_sche_drain
//
// Drives pkt_sche_drain with directed phases followed by a randomized phase.
// A behavioural model (integer fill, credit and tick counters plus a queue of
// words taken from the scheduler) predicts the handshake outputs each cycle;
// a separate monitor compares every word the DUT presents on tx against the
// head of the expected-word queue.
// ----------------------------------------------------------------------------
module tb_pkt_sche_drain;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  localparam int M_INIT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  logic          clk;
  logic          rst;
  logic          sch_ready;
  logic          sch_out_valid;
  logic [DW-1:0] sch_out_data;
  logic          sch_out_deque_en;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic [15:0]   cfg_tick_period;
  logic [CW-1:0] cfg_tokens;
  logic [CW-1:0] cfg_bucket_max;
  logic          flush_req;
  logic          flush_done;
`ifdef PKT_SCHE_DRAIN_STATS_EN
  logic [31:0]   drain_cnt;
`endif

  pkt_sche_drain #(
    .DWIDTH     (DW),
    .BUF_DEPTH  (DEPTH),
    .CRED_WIDTH (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sch_ready        (sch_ready),
    .sch_out_valid    (sch_out_valid),
    .sch_out_data     (sch_out_data),
    .sch_out_deque_en (sch_out_deque_en),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_data          (tx_data),
    .cfg_tick_period  (cfg_tick_period),
    .cfg_tokens       (cfg_tokens),
    .cfg_bucket_max   (cfg_bucket_max),
    .flush_req        (flush_req),
    .flush_done       (flush_done)
`ifdef PKT_SCHE_DRAIN_STATS_EN
    ,
    .drain_cnt        (drain_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          m_state;
  int          m_fill;
  int          m_credit;
  int          m_tick;
  logic [DW-1:0] exp_q[$];

  // Observation counters
  int deq_cnt  = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int beats_since_rst = 0;

  // Scheduler emulation
  logic deq_seen = 1'b0;
  int   sch_avail = 0;
  bit   sch_always = 1'b0;

  bit   e_deq;
  bit   e_txv;
  bit   e_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: predicts handshake outputs for this cycle, then advances
  // its own state to what it must be after the next rising edge.
  always @(negedge clk) begin
    if (sch_out_deque_en) deq_cnt++;
    if (flush_done) done_cnt++;
    if (rst) begin
      chk("rst_deque_en", 64'(sch_out_deque_en), 64'd0);
      chk("rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("rst_flush_done", 64'(flush_done), 64'd0);
      chk("rst_tx_data", 64'(tx_data), 64'd0);
      m_state  = M_INIT;
      m_fill   = 0;
      m_credit = 0;
      m_tick   = 0;
      exp_q.delete();
      beats_since_rst = 0;
    end else begin
      e_deq  = (m_state == M_RUN) && sch_out_valid && (m_fill < DEPTH) &&
               ((m_credit != 0) || (cfg_tick_period == 16'd0));
      e_txv  = (m_fill != 0);
      e_done = (m_state == M_FLUSH) && (m_fill == 0) && !flush_req;
      chk("deque_en", 64'(sch_out_deque_en), 64'(e_deq));
      chk("tx_valid", 64'(tx_valid), 64'(e_txv));
      chk("flush_done", 64'(flush_done), 64'(e_done));
      if (e_deq) exp_q.push_back(sch_out_data);
      m_fill = m_fill + int'(e_deq) - int'(e_txv && tx_ready);
      if (cfg_tick_period == 16'd0) begin
        m_tick   = 0;
        m_credit = int'(cfg_bucket_max);
      end else if (m_tick + 1 >= int'(cfg_tick_period)) begin
        m_tick   = 0;
        m_credit = m_credit + int'(cfg_tokens) - int'(e_deq);
        if (m_credit > int'(cfg_bucket_max)) m_credit = int'(cfg_bucket_max);
      end else begin
        m_tick   = m_tick + 1;
        m_credit = m_credit - int'(e_deq);
      end
      case (m_state)
        M_INIT:  if (sch_ready) m_state = M_RUN;
        M_RUN:   if (flush_req) m_state = M_FLUSH;
        default: if (e_done) m_state = M_RUN;
      endcase
    end
    deq_seen = sch_out_deque_en;
  end

  // Monitor: whenever the DUT presents a word, it must be the oldest word
  // still owed; a handshake retires it.
  always @(negedge clk) begin
    if (!rst && tx_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tx_unexpected: got word %0h expected none at %0t", tx_data, $time);
      end else begin
        chk("tx_data", 64'(tx_data), 64'(exp_q[0]));
        if (tx_ready) void'(exp_q.pop_front());
      end
      if (tx_ready) begin
        beat_cnt++;
        beats_since_rst++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (deq_seen) begin
      sch_out_data = $urandom;
      if (sch_avail > 0) sch_avail--;
    end
    sch_out_valid = sch_always || (sch_avail > 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_stats();
`ifdef PKT_SCHE_DRAIN_STATS_EN
    chk("drain_cnt", 64'(drain_cnt), 64'(beats_since_rst));
`endif
  endtask

  int base_deq;
  int base_beat;
  int base_done;
  int flush_left;

  initial begin
    rst             = 1'b1;
    sch_ready       = 1'b0;
    sch_out_valid   = 1'b1;
    sch_out_data    = $urandom;
    tx_ready        = 1'b1;
    cfg_tick_period = 16'd0;
    cfg_tokens      = 8'd0;
    cfg_bucket_max  = 8'd8;
    flush_req       = 1'b0;
    sch_always      = 1'b1;
    flush_left      = 0;

    // Reset, then INIT with scheduler valid but not ready.
    steps(3);
    rst = 1'b0;
    base_deq = deq_cnt;
    steps(5);
    chk("init_no_deq", 64'(deq_cnt - base_deq), 64'd0);
    sch_ready = 1'b1;
    steps(4);

    // Drain, then backpressure with six words offered.
    sch_always = 1'b0;
    sch_avail  = 0;
    steps(8);
    tx_ready  = 1'b0;
    sch_avail = 6;
    base_deq  = deq_cnt;
    steps(10);
    chk("bp_deq_count", 64'(deq_cnt - base_deq), 64'd4);
    tx_ready = 1'b1;
    steps(10);
    chk_stats();

    // Rate limiting.
    cfg_tick_period = 16'd10;
    cfg_tokens      = 8'd2;
    cfg_bucket_max  = 8'd2;
    sch_always      = 1'b1;
    steps(20);
    base_deq = deq_cnt;
    steps(100);
    chk("rate_deq_count", 64'(deq_cnt - base_deq), 64'd20);

    // Flush with three words buffered.
    cfg_tick_period = 16'd0;
    cfg_bucket_max  = 8'd8;
    sch_always      = 1'b0;
    sch_avail       = 0;
    steps(8);
    tx_ready  = 1'b0;
    sch_avail = 3;
    steps(6);
    flush_req  = 1'b1;
    tx_ready   = 1'b1;
    sch_always = 1'b1;
    base_deq   = deq_cnt;
    base_beat  = beat_cnt;
    steps(8);
    chk("flush_no_deq", 64'(deq_cnt - base_deq), 64'd0);
    chk("flush_beats", 64'(beat_cnt - base_beat), 64'd3);
    flush_req  = 1'b0;
    sch_always = 1'b0;
    base_done  = done_cnt;
    steps(3);
    chk("flush_done_pulses", 64'(done_cnt - base_done), 64'd1);

    // Reset with three words buffered, rate-limited afterwards.
    tx_ready  = 1'b0;
    sch_avail = 3;
    steps(6);
    rst             = 1'b1;
    cfg_tick_period = 16'd7;
    cfg_tokens      = 8'd1;
    cfg_bucket_max  = 8'd3;
    step();
    rst        = 1'b0;
    sch_always = 1'b1;
    tx_ready   = 1'b1;
    base_deq   = deq_cnt;
    steps(5);
    chk("post_rst_no_deq", 64'(deq_cnt - base_deq), 64'd0);
    steps(30);
    chk_stats();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom % 3)
          0:       cfg_tick_period = 16'd0;
          1:       cfg_tick_period = 16'd3;
          default: cfg_tick_period = 16'($urandom_range(2, 8));
        endcase
        cfg_tokens     = 8'($urandom_range(0, 3));
        cfg_bucket_max = 8'($urandom_range(1, 4));
      end
      sch_always = (($urandom % 4) != 0);
      tx_ready   = (($urandom % 3) != 0);
      if (flush_left > 0) begin
        flush_left--;
        flush_req = (flush_left != 0);
      end else if (($urandom % 80) == 0) begin
        flush_req  = 1'b1;
        flush_left = $urandom_range(1, 10);
      end
      rst = (($urandom % 700) == 0);
      step();
    end
    rst        = 1'b0;
    flush_req  = 1'b0;
    sch_always = 1'b0;
    sch_avail  = 0;
    tx_ready   = 1'b1;
    steps(10);
    chk_stats();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
